uart_matrix_loader: RTL and testbench
=====================================

// Module: uart_matrix_loader
// PURPOSE
//  Byte-stream frame parser between the UART receiver and matrix operand RAMs.
//  Frame: 1 size byte N, then N*N elements of A, then N*N elements of B; row-major, little-endian.
//  Generalised over element width and maximum dimension. Adds size checking, inter-byte timeout and error reporting.
// PARAMETERS
//  MAX_N        16        largest accepted dimension N (1..255)
//  ELEM_BYTES   1         bytes per element (1..4); ELEM_W = 8*ELEM_BYTES
//  TIMEOUT_CYC  2000000   idle clk cycles mid-frame before abort (~40 ms at 50 MHz)
//  ADDR_W       localparam clog2(MAX_N*MAX_N); DIM_W = 8
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-low reset
//  rx_valid  in   1       one-cycle strobe, rx_data valid
//  rx_data   in   8       received byte
//  wr_en     out  1       one-cycle RAM write strobe
//  wr_sel    out  1       0 = matrix A, 1 = matrix B
//  wr_addr   out  ADDR_W  row-major element index, 0..N*N-1
//  wr_data   out  ELEM_W  assembled element
//  dim       out  DIM_W   accepted N; held until next valid size byte
//  busy      out  1       high in S_LOAD_A / S_LOAD_B
//  load_done out  1       one-cycle pulse, frame complete
//  err       out  1       one-cycle pulse, frame aborted
//  err_code  out  2       0 none, 1 BAD_SIZE, 2 TIMEOUT; held until next err
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs 0, state S_SIZE, counters/assembler cleared. Applies mid-frame; partial data is discarded and no done/err pulse is issued.
//  States: S_SIZE -> S_LOAD_A -> S_LOAD_B -> S_SIZE. There is no separate done state.
//  S_SIZE: a byte with 1<=N<=MAX_N sets dim=N, elem idx=0, byte cnt=0, and moves to S_LOAD_A.
//   A byte of 0 or >MAX_N: err pulse, err_code=1, stay in S_SIZE, dim unchanged.
//  S_LOAD_*: each rx_valid shifts rx_data into byte slot cnt (byte 0 = LSBs).
//   On the ELEM_BYTES-th byte, on the next cycle: wr_en=1, wr_data=element, wr_addr=idx, wr_sel=state.
//   idx increments; latency is exactly 1 clk from the last byte strobe to wr_en.
//  Last A element (idx==N*N-1): idx wraps to 0, go to S_LOAD_B. The first B byte may arrive the very next cycle.
//  Last B element: wr_en and load_done in the same cycle; state is S_SIZE in that cycle.
//   A rx_valid in that cycle is parsed as a new size byte.
//  Timeout: counter clears on every rx_valid and counts only while busy.
//   At TIMEOUT_CYC: err pulse, err_code=2, return to S_SIZE, partial element dropped, no wr_en.
//   Writes already issued stay valid.
//  rx_valid coinciding with the timeout terminal count: the byte wins and the counter clears.
//  wr_en, load_done and err are registered and never asserted together except wr_en+load_done.
//  dim and wr_addr stay stable between strobes. wr_data holds its last value.
//  Widths: idx counter ADDR_W+1 bits. N*N is computed once at size accept into a registered ADDR_W+1 limit.
// STRUCTURE
//  matrix_pkg: err code constants (ERR_NONE/BAD_SIZE/TIMEOUT), state encoding, clog2 function, shared with the multiplier and TX formatter.
//  Sub-module elem_assembler (ELEM_BYTES param): byte shift-in, byte counter, full strobe, clear.
//  Top: FSM, idx/limit counters, timeout counter, output registers.
// TESTING
//  1 Reset, N=2, ELEM_BYTES=1, A=01..04, B=FF..FC
//    -> 8 wr_en at addr 0..3 (A), then 0..3 (B); load_done with the 8th wr_en; dim=2.
//  2 Size byte 0x00, then 0x11 (MAX_N=16)
//    -> two err pulses, err_code=1, no wr_en, dim stays 0, busy low.
//  3 N=3, 5 bytes then silence
//    -> 5 writes, err at TIMEOUT_CYC after the last byte, err_code=2, busy drops, next 0x01 accepted.
//  4 ELEM_BYTES=2, N=1, bytes 34 12 CD AB
//    -> wr_data 0x1234 (A, addr 0), then 0xABCD (B, addr 0); load_done.
//  5 rst low 2 clks during B load of N=10
//    -> all outputs 0, no load_done/err; a fresh N=10 frame completes with 200 writes.
//  6 New size byte 0x04 in the load_done cycle
//    -> accepted, dim=4, busy=1 next cycle, no byte lost.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix datapath: error codes, loader state encoding, clog2 helper.
// No logic; constants only.
// Imported by the UART loader, the multiplier and the TX formatter.
package matrix_pkg;

  localparam int DIM_W = 8;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_SIZE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // Loader FSM encoding
  localparam logic [1:0] S_SIZE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;

  // Ceiling log2, never below 1 so that derived vector widths stay legal
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_matrix_loader_elem_assembler.sv
// Packs a little-endian byte stream into ELEM_BYTES-wide elements.
// Latency: 'full' and 'elem' are combinational with the final byte strobe.
// No backpressure: every byte strobe is consumed in the cycle it arrives.
module elem_assembler
  import matrix_pkg::*;
#(
  parameter int ELEM_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    byte_vld,
  input  logic [7:0]              byte_dat,
  output logic                    full,
  output logic [8*ELEM_BYTES-1:0] elem
);

  localparam int               CNT_W     = clog2(ELEM_BYTES);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ELEM_BYTES - 1);

  logic [CNT_W-1:0]        cnt;
  logic [8*ELEM_BYTES-1:0] shreg;

  // Element as it looks with the incoming byte dropped into its slot
  always_comb begin
    full = byte_vld && (cnt == LAST_SLOT);
    elem = shreg;
    elem[8*cnt +: 8] = byte_dat;
  end

  // Capture bytes and advance the slot counter, wrapping after the last slot
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_vld) begin
      shreg <= elem;
      cnt   <= full ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_matrix_loader.sv
// Parses a UART byte frame (size N, N*N A elements, N*N B elements) into operand RAM writes.
// Latency: one clk from the last byte of an element to wr_en; load_done rides on the final write.
// No backpressure: the RAM write port always accepts; an idle line mid-frame aborts after TIMEOUT_CYC.
module uart_matrix_loader
  import matrix_pkg::*;
#(
  parameter int  MAX_N       = 16,
  parameter int  ELEM_BYTES  = 1,
  parameter int  TIMEOUT_CYC = 2000000,
  localparam int ADDR_W      = clog2(MAX_N * MAX_N),
  localparam int ELEM_W      = 8 * ELEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ELEM_W-1:0] wr_data,
  output logic [DIM_W-1:0]  dim,
  output logic              busy,
  output logic              load_done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int               LIM_W    = ADDR_W + 1;
  localparam int               TMO_W    = clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]        state;
  logic [LIM_W-1:0]  idx;
  logic [LIM_W-1:0]  limit;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              busy_st;
  logic              byte_in;
  logic              size_ok;
  logic              accept_size;
  logic              reject_size;
  logic              timeout_hit;
  logic              elem_full;
  logic              write_elem;
  logic              last_elem;
  logic [ELEM_W-1:0] elem;
  logic [LIM_W-1:0]  limit_next;

  elem_assembler #(
    .ELEM_BYTES (ELEM_BYTES)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (!busy_st),
    .byte_vld (byte_in),
    .byte_dat (rx_data),
    .full     (elem_full),
    .elem     (elem)
  );

  // Per-cycle decisions; a byte arriving on the terminal timeout count wins
  always_comb begin
    busy_st     = (state == S_LOAD_A) || (state == S_LOAD_B);
    byte_in     = rx_valid && busy_st;
    size_ok     = (rx_data != 8'd0) && (int'(rx_data) <= MAX_N);
    accept_size = (state == S_SIZE) && rx_valid && size_ok;
    reject_size = (state == S_SIZE) && rx_valid && !size_ok;
    timeout_hit = busy_st && !rx_valid && (tmo_cnt == TMO_LAST);
    write_elem  = busy_st && elem_full;
    last_elem   = write_elem && (idx == limit - LIM_W'(1));
    limit_next  = LIM_W'(rx_data) * LIM_W'(rx_data);
  end

  assign busy = busy_st;

  // Frame sequencing: size accept, element index, A->B handover, abort on timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_SIZE;
      idx   <= '0;
      limit <= '0;
      dim   <= '0;
    end else begin
      case (state)
        S_SIZE: begin
          if (accept_size) begin
            state <= S_LOAD_A;
            dim   <= rx_data;
            limit <= limit_next;
            idx   <= '0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (timeout_hit) begin
            state <= S_SIZE;
            idx   <= '0;
          end else if (last_elem) begin
            idx   <= '0;
            state <= (state == S_LOAD_A) ? S_LOAD_B : S_SIZE;
          end else if (write_elem) begin
            idx <= idx + LIM_W'(1);
          end
        end
        default: begin
          state <= S_SIZE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Registered write port and status strobes; data and address hold between writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
      if (reject_size) begin
        err      <= 1'b1;
        err_code <= ERR_BAD_SIZE;
      end else if (timeout_hit) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (write_elem) begin
        wr_en     <= 1'b1;
        wr_sel    <= (state == S_LOAD_B);
        wr_addr   <= idx[ADDR_W-1:0];
        wr_data   <= elem;
        load_done <= last_elem && (state == S_LOAD_B);
      end
    end
  end

  // Idle-line counter: runs only mid-frame, cleared by every received byte
  always_ff @(posedge clk) begin
    if (!rst || !busy_st || rx_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: random frames against a frame-level reference model.
// Two instances: 1-byte elements and 2-byte elements, both with a short timeout.
// Inputs change 1 time unit after the rising edge; outputs are recorded on the falling edge.
module tb_uart_matrix_loader;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid2 = 1'b0;
  logic [7:0]  rx_data2 = 8'h00;

  logic        wr_en, wr_sel, busy, load_done, err;
  logic [7:0]  wr_addr, wr_data, dim;
  logic [1:0]  err_code;

  logic        wr_en2, wr_sel2, busy2, load_done2, err2;
  logic [7:0]  wr_addr2, dim2;
  logic [15:0] wr_data2;
  logic [1:0]  err_code2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_matrix_loader #(.MAX_N(16), .ELEM_BYTES(1), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .dim(dim), .busy(busy), .load_done(load_done), .err(err), .err_code(err_code)
  );

  uart_matrix_loader #(.MAX_N(16), .ELEM_BYTES(2), .TIMEOUT_CYC(TMO)) dut2 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .dim(dim2), .busy(busy2), .load_done(load_done2), .err(err2), .err_code(err_code2)
  );

  typedef struct {int sel; int addr; int data; int done; int cyc;} wr_t;
  typedef struct {int code; int cyc;} er_t;

  wr_t got1[$];
  wr_t got2[$];
  wr_t exp_q[$];
  er_t errs1[$];
  er_t errs2[$];
  int  frame_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int bad_combo = 0;
  int last_send_cyc = 0;

  // Output recorder: every write and every error pulse, with the cycle it appeared in
  always @(negedge clk) begin
    if (wr_en) got1.push_back('{sel: int'(wr_sel), addr: int'(wr_addr), data: int'(wr_data),
                                done: int'(load_done), cyc: cyc});
    if (err) errs1.push_back('{code: int'(err_code), cyc: cyc});
    if (load_done && !wr_en) bad_combo++;
    if (err && (wr_en || load_done)) bad_combo++;
    if (wr_en2) got2.push_back('{sel: int'(wr_sel2), addr: int'(wr_addr2), data: int'(wr_data2),
                                 done: int'(load_done2), cyc: cyc});
    if (err2) errs2.push_back('{code: int'(err_code2), cyc: cyc});
    if (load_done2 && !wr_en2) bad_combo++;
    if (err2 && (wr_en2 || load_done2)) bad_combo++;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    if (d == 0) begin rx_valid = 1'b1; rx_data = b; end
    else begin rx_valid2 = 1'b1; rx_data2 = b; end
    last_send_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
    rx_valid2 = 1'b0;
    tick(gap);
  endtask

  task automatic send_range(input int d, input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++)
      send_byte(d, 8'(frame_q[i]), (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic make_frame(input int n, input int eb);
    frame_q.push_back(n);
    repeat (2 * n * n * eb) frame_q.push_back(int'($urandom_range(255, 0)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_valid2 = 1'b0;
    tick(n);
    rst = 1'b1;
    got1.delete(); got2.delete(); errs1.delete(); errs2.delete(); frame_q.delete();
  endtask

  // Reference: every frame in frame_q yields N*N A writes then N*N B writes,
  // element = little-endian sum of its bytes, load_done only on the final B write
  function automatic void build_expect(input int eb);
    int pos, n, nn, data;
    exp_q.delete();
    pos = 0;
    while (pos < frame_q.size()) begin
      n = frame_q[pos];
      nn = n * n;
      for (int e = 0; e < 2 * nn; e++) begin
        data = 0;
        for (int k = 0; k < eb; k++) data += frame_q[pos + 1 + e * eb + k] << (8 * k);
        exp_q.push_back('{sel: (e >= nn) ? 1 : 0, addr: e % nn, data: data,
                          done: (e == 2 * nn - 1) ? 1 : 0, cyc: 0});
      end
      pos += 1 + 2 * nn * eb;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    n_checks++; if (wr_en !== 1'b0 || load_done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: wr_en=%b load_done=%b err=%b, want 0", wr_en, load_done, err); end
    n_checks++; if (wr_addr !== 8'd0 || wr_data !== 8'd0 || wr_sel !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr: addr=%h data=%h sel=%b, want 0", wr_addr, wr_data, wr_sel); end
    n_checks++; if (dim !== 8'd0 || busy !== 1'b0 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL reset_status: dim=%h busy=%b err_code=%0d, want 0", dim, busy, err_code); end
    n_checks++; if (wr_en2 !== 1'b0 || wr_data2 !== 16'd0 || dim2 !== 8'd0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut2: wr_en=%b data=%h dim=%h busy=%b, want 0", wr_en2, wr_data2, dim2, busy2); end
    do_reset(1);
  endtask

  task automatic test_basic();
    do_reset(2);
    frame_q = '{2, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
    send_range(0, 0, frame_q.size() - 1, 0);
    tick(3);
    build_expect(1);
    n_checks++; if (got1.size() !== 8) begin
      n_fail++; $display("FAIL basic_count: got %0d writes, want 8", got1.size()); end
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
      n_checks++;
      if (got1[i].sel !== exp_q[i].sel || got1[i].addr !== exp_q[i].addr ||
          got1[i].data !== exp_q[i].data || got1[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL basic_wr[%0d]: got sel=%0d addr=%0d data=%h done=%0d, want sel=%0d addr=%0d data=%h done=%0d",
          i, got1[i].sel, got1[i].addr, got1[i].data, got1[i].done, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].done); end
    end
    n_checks++; if (dim !== 8'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: dim=%0d busy=%b, want 2 and 0", dim, busy); end
  endtask

  task automatic test_random_frames();
    do_reset(2);
    for (int f = 0; f < 3; f++) make_frame(int'($urandom_range(6, 1)), 1);
    make_frame(16, 1);
    send_range(0, 0, frame_q.size() - 1, 3);
    tick(3);
    build_expect(1);
    n_checks++; if (got1.size() !== exp_q.size() || errs1.size() !== 0) begin
      n_fail++; $display("FAIL rand_count: got %0d writes %0d errs, want %0d and 0", got1.size(), errs1.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
      n_checks++;
      if (got1[i].sel !== exp_q[i].sel || got1[i].addr !== exp_q[i].addr ||
          got1[i].data !== exp_q[i].data || got1[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL rand_wr[%0d]: got sel=%0d addr=%0d data=%h done=%0d, want sel=%0d addr=%0d data=%h done=%0d",
          i, got1[i].sel, got1[i].addr, got1[i].data, got1[i].done, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].done); end
    end
    n_checks++; if (dim !== 8'd16) begin
      n_fail++; $display("FAIL rand_dim: dim=%0d, want 16", dim); end
  endtask

  task automatic test_bad_size();
    do_reset(2);
    frame_q = '{8'h00, 8'h11, int'($urandom_range(255, 17))};
    send_range(0, 0, 2, 1);
    tick(3);
    n_checks++; if (errs1.size() !== 3 || got1.size() !== 0) begin
      n_fail++; $display("FAIL badsize_count: %0d errs %0d writes, want 3 and 0", errs1.size(), got1.size()); end
    for (int i = 0; i < errs1.size(); i++) begin
      n_checks++; if (errs1[i].code !== 1) begin
        n_fail++; $display("FAIL badsize_code[%0d]: code=%0d, want 1", i, errs1[i].code); end
    end
    n_checks++; if (dim !== 8'd0 || busy !== 1'b0 || err_code !== 2'd1) begin
      n_fail++; $display("FAIL badsize_status: dim=%0d busy=%b err_code=%0d, want 0 0 1", dim, busy, err_code); end
    send_byte(0, 8'd16, 0);
    n_checks++; if (dim !== 8'd16 || busy !== 1'b1) begin
      n_fail++; $display("FAIL maxsize_accept: dim=%0d busy=%b, want 16 and 1", dim, busy); end
  endtask

  task automatic test_timeout();
    int c;
    do_reset(2);
    frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_byte(0, 8'(frame_q[0]), 0);
    // The next byte lands exactly on the terminal idle count and must be taken
    send_byte(0, 8'(frame_q[1]), TMO - 1);
    send_range(0, 2, 5, 0);
    c = last_send_cyc;
    tick(TMO + 10);
    n_checks++; if (got1.size() !== 5) begin
      n_fail++; $display("FAIL tmo_writes: got %0d writes, want 5", got1.size()); end
    for (int i = 0; i < 5 && i < got1.size(); i++) begin
      n_checks++; if (got1[i].sel !== 0 || got1[i].addr !== i || got1[i].data !== frame_q[1 + i] || got1[i].done !== 0) begin
        n_fail++; $display("FAIL tmo_wr[%0d]: got sel=%0d addr=%0d data=%h, want 0 %0d %h", i, got1[i].sel, got1[i].addr, got1[i].data, i, frame_q[1 + i]); end
    end
    // Timeout error lands TMO clocks after the edge that took the last byte
    n_checks++; if (errs1.size() !== 1) begin
      n_fail++; $display("FAIL tmo_errcount: %0d errs, want 1", errs1.size()); end
    else begin
      n_checks++; if (errs1[0].code !== 2 || errs1[0].cyc - c !== TMO + 1) begin
        n_fail++; $display("FAIL tmo_err: code=%0d delay=%0d, want 2 and %0d", errs1[0].code, errs1[0].cyc - c, TMO + 1); end
    end
    n_checks++; if (busy !== 1'b0 || err_code !== 2'd2) begin
      n_fail++; $display("FAIL tmo_status: busy=%b err_code=%0d, want 0 and 2", busy, err_code); end
    send_byte(0, 8'h01, 0);
    n_checks++; if (busy !== 1'b1 || dim !== 8'd1) begin
      n_fail++; $display("FAIL tmo_recover: busy=%b dim=%0d, want 1 and 1", busy, dim); end
    send_byte(0, 8'h5A, 0);
    send_byte(0, 8'hA5, 2);
    n_checks++; if (busy !== 1'b0 || got1.size() !== 7 || got1[6].done !== 1) begin
      n_fail++; $display("FAIL tmo_after_frame: busy=%b writes=%0d, want 0 and 7 with done", busy, got1.size()); end
  endtask

  task automatic test_elem16();
    do_reset(2);
    frame_q = '{1, 8'h34, 8'h12, 8'hCD, 8'hAB};
    make_frame(int'($urandom_range(4, 2)), 2);
    send_range(1, 0, frame_q.size() - 1, 2);
    tick(3);
    build_expect(2);
    n_checks++; if (got2.size() !== exp_q.size() || got2.size() < 2) begin
      n_fail++; $display("FAIL e16_count: got %0d writes, want %0d", got2.size(), exp_q.size()); end
    else begin
      n_checks++; if (got2[0].data !== 32'h1234 || got2[1].data !== 32'hABCD || got2[1].sel !== 1 || got2[1].done !== 1) begin
        n_fail++; $display("FAIL e16_first: got %h/%h sel=%0d done=%0d, want 1234/abcd 1 1", got2[0].data, got2[1].data, got2[1].sel, got2[1].done); end
    end
    for (int i = 0; i < exp_q.size() && i < got2.size(); i++) begin
      n_checks++;
      if (got2[i].sel !== exp_q[i].sel || got2[i].addr !== exp_q[i].addr ||
          got2[i].data !== exp_q[i].data || got2[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL e16_wr[%0d]: got sel=%0d addr=%0d data=%h done=%0d, want sel=%0d addr=%0d data=%h done=%0d",
          i, got2[i].sel, got2[i].addr, got2[i].data, got2[i].done, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].done); end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    do_reset(2);
    make_frame(10, 1);
    send_range(0, 0, 130, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    n_checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || dim !== 8'd0 || wr_data !== 8'd0 || wr_addr !== 8'd0 ||
                    load_done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || wr_sel !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: wr_en=%b busy=%b dim=%0d data=%h addr=%0d, want all 0", wr_en, busy, dim, wr_data, wr_addr); end
    rst = 1'b1;
    tick(5);
    dones = 0;
    foreach (got1[i]) dones += got1[i].done;
    n_checks++; if (got1.size() !== 130 || dones !== 0 || errs1.size() !== 0) begin
      n_fail++; $display("FAIL midrst_events: writes=%0d dones=%0d errs=%0d, want 130 0 0", got1.size(), dones, errs1.size()); end
    got1.delete(); frame_q.delete();
    make_frame(10, 1);
    send_range(0, 0, frame_q.size() - 1, 1);
    tick(3);
    build_expect(1);
    n_checks++; if (got1.size() !== 200) begin
      n_fail++; $display("FAIL midrst_fresh_count: got %0d writes, want 200", got1.size()); end
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
      n_checks++;
      if (got1[i].sel !== exp_q[i].sel || got1[i].addr !== exp_q[i].addr ||
          got1[i].data !== exp_q[i].data || got1[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL midrst_wr[%0d]: got sel=%0d addr=%0d data=%h done=%0d, want sel=%0d addr=%0d data=%h done=%0d",
          i, got1[i].sel, got1[i].addr, got1[i].data, got1[i].done, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].done); end
    end
  endtask

  task automatic test_back_to_back();
    int size_cyc;
    do_reset(2);
    make_frame(1, 1);
    make_frame(4, 1);
    send_range(0, 0, 3, 0);
    size_cyc = last_send_cyc;
    n_checks++; if (dim !== 8'd4 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: dim=%0d busy=%b, want 4 and 1", dim, busy); end
    send_range(0, 4, frame_q.size() - 1, 2);
    tick(3);
    build_expect(1);
    n_checks++; if (got1.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes, want %0d", got1.size(), exp_q.size()); end
    else begin
      n_checks++; if (got1[1].done !== 1 || got1[1].cyc !== size_cyc) begin
        n_fail++; $display("FAIL b2b_overlap: done=%0d in cycle %0d, want 1 in cycle %0d", got1[1].done, got1[1].cyc, size_cyc); end
    end
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
      n_checks++;
      if (got1[i].sel !== exp_q[i].sel || got1[i].addr !== exp_q[i].addr ||
          got1[i].data !== exp_q[i].data || got1[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL b2b_wr[%0d]: got sel=%0d addr=%0d data=%h done=%0d, want sel=%0d addr=%0d data=%h done=%0d",
          i, got1[i].sel, got1[i].addr, got1[i].data, got1[i].done, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].done); end
    end
  endtask

  task automatic test_exclusive();
    n_checks++; if (bad_combo !== 0) begin
      n_fail++; $display("FAIL strobe_exclusive: %0d illegal strobe combinations, want 0", bad_combo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_frames();
    test_bad_size();
    test_timeout();
    test_elem16();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
